mem_lsu: RTL

//  Multi-cycle load/store unit for the RV32I MEM stage. Sits between ex_mem and mem_wb.

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_align.sv | 50 +++++
 rtl/mem_lsu.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit.
// Holds the funct3 size codes, the exception cause codes, the LSU state enum,
// and small helpers that compute byte enables and alignment from size and offset.
package lsu_pkg;

  // funct3 encodings of the access size
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // exc_cause encodings
  localparam logic [1:0] CAUSE_LD_MIS = 2'b00;
  localparam logic [1:0] CAUSE_ST_MIS = 2'b01;
  localparam logic [1:0] CAUSE_LD_FLT = 2'b10;
  localparam logic [1:0] CAUSE_ST_FLT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } lsu_state_e;

  // Byte enables for an access of the given size at byte offset off.
  // size[1:0] alone selects the width; the unsigned flag in size[2] is irrelevant here.
  function automatic logic [3:0] be_for(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Halfwords need an even address, words a multiple of four.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    logic mis;
    case (size[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the load/store unit.
// Ports:
//   size, off    captured funct3 size and byte offset of the access
//   store_data   raw store operand
//   be           byte enables for the bus
//   wdata        store data replicated into every lane it may occupy
//   rdata        raw bus read word
//   load_data    selected byte/half/word, sign- or zero-extended
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        size,
  input  logic [1:0]        off,
  input  logic [XLEN-1:0]   store_data,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   load_data
);

  logic [XLEN-1:0] shifted;

  assign be = be_for(size, off);

  // Replicating the operand means the slave can pick any enabled lane
  // without needing its own shifter.
  always_comb begin
    case (size[1:0])
      2'b00:   wdata = {(XLEN/8){store_data[7:0]}};
      2'b01:   wdata = {(XLEN/16){store_data[15:0]}};
      default: wdata = store_data;
    endcase
  end

  // Move the addressed byte/halfword down to bit 0 before extending.
  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    case (size)
      SZ_B:    load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      SZ_BU:   load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      SZ_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      SZ_HU:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Multi-cycle load/store unit for the RV32I MEM stage (between ex_mem and mem_wb).
// Drives a req/gnt/rvalid data bus, stalls the pipeline until the access
// completes, aligns load data and reports misaligned, faulting or timed-out accesses.
// Ports:
//   clk, rst_n                clock and synchronous active-low reset
//   flush_i                   pipeline redirect, kills the current access
//   rd_addr_i/rd_data_i/rd_wen_i   writeback info from ex_mem
//   mem_addr_i/mem_data_i/mem_size_i/mem_we_i/mem_re_i   memory access from ex_mem
//   bus_req_o/bus_we_o/bus_addr_o/bus_be_o/bus_wdata_o   bus request channel
//   bus_gnt_i                 request accepted
//   bus_rvalid_i/bus_rdata_i/bus_err_i   bus response channel
//   stall_o                   hold ex_mem and upstream
//   rd_addr_o/rd_data_o/rd_wen_o   writeback info to mem_wb
//   exc_o/exc_cause_o         one-cycle exception pulse and cause
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [XLEN-1:0]   rd_data_i,
  input  logic              rd_wen_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic [2:0]        mem_size_i,
  input  logic              mem_we_i,
  input  logic              mem_re_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [XLEN/8-1:0] bus_be_o,
  output logic [XLEN-1:0]   bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [XLEN-1:0]   bus_rdata_i,
  input  logic              bus_err_i,
  output logic              stall_o,
  output logic [4:0]        rd_addr_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              rd_wen_o,
  output logic              exc_o,
  output logic [1:0]        exc_cause_o
);

  localparam int WD_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  lsu_state_e        state, state_next;
  logic [WD_W-1:0]   wd_cnt;
  logic              wd_hit;
  logic              capture;

  logic [ADDR_W-1:0] cap_addr;
  logic [2:0]        cap_size;
  logic              cap_we;
  logic [XLEN-1:0]   cap_wdata;
  logic [4:0]        cap_rd_addr;
  logic              cap_rd_wen;

  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata_rep;
  logic [XLEN-1:0]   load_data;
  logic [1:0]        fault_cause;

  lsu_align #(.XLEN(XLEN)) u_align (
    .size       (cap_size),
    .off        (cap_addr[1:0]),
    .store_data (cap_wdata),
    .be         (be),
    .wdata      (wdata_rep),
    .rdata      (bus_rdata_i),
    .load_data  (load_data)
  );

  // MAX_WAIT=0 disables the watchdog entirely.
  assign wd_hit      = (MAX_WAIT != 0) && (wd_cnt == WD_W'(MAX_WAIT));
  assign fault_cause = cap_we ? CAUSE_ST_FLT : CAUSE_LD_FLT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wd_cnt      <= '0;
      cap_addr    <= '0;
      cap_size    <= '0;
      cap_we      <= 1'b0;
      cap_wdata   <= '0;
      cap_rd_addr <= '0;
      cap_rd_wen  <= 1'b0;
    end else begin
      state <= state_next;
      // Counter measures time spent in the current state only.
      if (state_next != state)
        wd_cnt <= '0;
      else if (state == ST_REQ || state == ST_RESP)
        wd_cnt <= wd_cnt + 1'b1;
      if (capture) begin
        cap_addr    <= mem_addr_i;
        cap_size    <= mem_size_i;
        cap_we      <= mem_we_i;
        cap_wdata   <= mem_data_i;
        cap_rd_addr <= rd_addr_i;
        cap_rd_wen  <= rd_wen_i;
      end
    end
  end

  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_be_o    = '0;
    bus_wdata_o = '0;
    stall_o     = 1'b0;
    rd_addr_o   = cap_rd_addr;
    rd_data_o   = load_data;
    rd_wen_o    = 1'b0;
    exc_o       = 1'b0;
    exc_cause_o = CAUSE_LD_MIS;

    case (state)
      ST_IDLE: begin
        if (!mem_re_i && !mem_we_i) begin
          rd_addr_o = rd_addr_i;
          rd_data_o = rd_data_i;
          rd_wen_o  = rd_wen_i;
        end else if (flush_i) begin
          // Access killed before it starts: nothing captured, nothing reported.
        end else if (is_misaligned(mem_size_i, mem_addr_i[1:0])) begin
          exc_o       = 1'b1;
          exc_cause_o = mem_we_i ? CAUSE_ST_MIS : CAUSE_LD_MIS;
        end else begin
          capture    = 1'b1;
          stall_o    = 1'b1;
          state_next = ST_REQ;
        end
      end

      ST_REQ: begin
        bus_req_o   = 1'b1;
        bus_we_o    = cap_we;
        bus_addr_o  = {cap_addr[ADDR_W-1:2], 2'b00};
        bus_be_o    = be;
        bus_wdata_o = wdata_rep;
        stall_o     = 1'b1;
        if (flush_i) begin
          // A granted request still owes us a response, which must be drained.
          state_next = bus_gnt_i ? ST_DRAIN : ST_IDLE;
        end else if (bus_gnt_i) begin
          state_next = ST_RESP;
        end else if (wd_hit) begin
          stall_o     = 1'b0;
          exc_o       = 1'b1;
          exc_cause_o = fault_cause;
          state_next  = ST_IDLE;
        end
      end

      ST_RESP: begin
        stall_o = !bus_rvalid_i;
        if (flush_i) begin
          state_next = bus_rvalid_i ? ST_IDLE : ST_DRAIN;
        end else if (bus_rvalid_i) begin
          state_next = ST_IDLE;
          if (bus_err_i) begin
            exc_o       = 1'b1;
            exc_cause_o = fault_cause;
          end else begin
            rd_wen_o = !cap_we && cap_rd_wen;
          end
        end else if (wd_hit) begin
          // The slave may still answer later; swallow that response in DRAIN.
          stall_o     = 1'b0;
          exc_o       = 1'b1;
          exc_cause_o = fault_cause;
          state_next  = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        stall_o = 1'b1;
        if (bus_rvalid_i)
          state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule
